// File: rtl/sin_dds_driver_if.sv
// Control, ROM-read and sample-return signals of sin_dds_driver.
// The slave modport is the DDS driver side; master is the controller/ROM side.
interface sin_dds_driver_if #(
    parameter int unsigned PHASE_W = 32
);
    logic               i_start;
    logic               i_stop;
    logic [PHASE_W-1:0] i_fcw;
    logic [15:0]        i_burst_len;
    logic               o_rom_en;
    logic [9:0]         o_rom_addr;
    logic               i_rom_vld;
    logic [15:0]        i_rom_data;
    logic               o_busy;
    logic               o_done;
    logic               o_sample_vld;
    logic [15:0]        o_sample;
    logic [15:0]        o_smp_cnt;
    logic [15:0]        o_max;
    logic [15:0]        o_min;

    modport slave (
        input  i_start, i_stop, i_fcw, i_burst_len, i_rom_vld, i_rom_data,
        output o_rom_en, o_rom_addr, o_busy, o_done, o_sample_vld, o_sample,
               o_smp_cnt, o_max, o_min
    );

    modport master (
        output i_start, i_stop, i_fcw, i_burst_len, i_rom_vld, i_rom_data,
        input  o_rom_en, o_rom_addr, o_busy, o_done, o_sample_vld, o_sample,
               o_smp_cnt, o_max, o_min
    );
endinterface

// File: rtl/sin_dds_driver.sv
// Phase-accumulator DDS front end: issues sine-ROM reads, drains in-flight
// returns and tracks returned samples. Peak tracking built only under SIN_DDS_PEAK_TRACK_EN.
module sin_dds_driver #(
    parameter int unsigned ROM_LAT = 2,
    parameter int unsigned PHASE_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    sin_dds_driver_if.slave dds_if
);
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SMP_W   = 16;
    localparam int unsigned DRAIN_W = $clog2(ROM_LAT + 2) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROM_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             state_q;
    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] acc_d;
    logic [PHASE_W-1:0] fcw_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   issue_q;
    logic [CNT_W-1:0]   issue_d;
    logic [DRAIN_W-1:0] drain_q;
    logic               rom_en_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               done_q;
    logic               smp_vld_q;
    logic [SMP_W-1:0]   smp_q;
    logic [CNT_W-1:0]   smp_cnt_q;
    logic               start_acc;
    logic               last_read;

    assign acc_d     = acc_q + fcw_q;
    assign issue_d   = issue_q + CNT_W'(1);
    assign last_read = (len_q != '0) && (issue_d == len_q);
    assign start_acc = (state_q == ST_IDLE) && dds_if.i_start;

    // Main FSM. DRAIN is timed from the last issued read so that o_done
    // lands ROM_LAT+2 cycles after the final o_rom_en, once its sample is in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            fcw_q      <= '0;
            len_q      <= '0;
            issue_q    <= '0;
            drain_q    <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            smp_vld_q  <= 1'b0;
            smp_q      <= '0;
            smp_cnt_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            rom_en_q  <= 1'b0;
            smp_vld_q <= dds_if.i_rom_vld;
            smp_q     <= dds_if.i_rom_data;
            if (dds_if.i_rom_vld && (smp_cnt_q != '1)) begin
                smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (dds_if.i_start) begin
                        fcw_q     <= dds_if.i_fcw;
                        len_q     <= dds_if.i_burst_len;
                        acc_q     <= '0;
                        issue_q   <= '0;
                        smp_cnt_q <= '0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dds_if.i_stop) begin
                        // No read this cycle, so one DRAIN cycle is already spent.
                        drain_q <= DRAIN_W'(1);
                        state_q <= ST_DRAIN;
                    end else begin
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= acc_q[PHASE_W-1 -: ADDR_W];
                        acc_q      <= acc_d;
                        issue_q    <= issue_d;
                        if (last_read) begin
                            drain_q <= '0;
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SIN_DDS_PEAK_TRACK_EN
    logic [SMP_W-1:0] max_q;
    logic [SMP_W-1:0] min_q;

    // Signed running peaks; a start re-seeds them to the opposite extremes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_q <= '0;
            min_q <= '0;
        end else if (start_acc) begin
            max_q <= 16'h8000;
            min_q <= 16'h7FFF;
        end else if (dds_if.i_rom_vld) begin
            if ($signed(dds_if.i_rom_data) > $signed(max_q)) begin
                max_q <= dds_if.i_rom_data;
            end
            if ($signed(dds_if.i_rom_data) < $signed(min_q)) begin
                min_q <= dds_if.i_rom_data;
            end
        end
    end

    assign dds_if.o_max = max_q;
    assign dds_if.o_min = min_q;
`else
    logic unused_start;
    assign unused_start = start_acc;
    assign dds_if.o_max = '0;
    assign dds_if.o_min = '0;
`endif

    assign dds_if.o_rom_en     = rom_en_q;
    assign dds_if.o_rom_addr   = rom_addr_q;
    assign dds_if.o_busy       = (state_q != ST_IDLE);
    assign dds_if.o_done       = done_q;
    assign dds_if.o_sample_vld = smp_vld_q;
    assign dds_if.o_sample     = smp_q;
    assign dds_if.o_smp_cnt    = smp_cnt_q;
endmodule
